// File: rtl/alu_operand_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
// Widths, FSM encoding and function-code bit positions.
package alu_operand_seq_pkg;

  localparam int WIDTH = 16;
  localparam int NREGS = 8;
  localparam int AW    = $clog2(NREGS);

  localparam int FUNC_SUB   = 0;
  localparam int FUNC_CHAIN = 1;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [AW-1:0]    addr_t;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_RDA  = 5'b00010,
    S_RDB  = 5'b00100,
    S_EXEC = 5'b01000,
    S_WB   = 5'b10000
  } state_e;

  typedef struct packed {
    addr_t      ra;
    addr_t      rb;
    addr_t      rd;
    logic [1:0] func;
  } cmd_t;

endpackage

// File: rtl/alu_operand_seq_if.sv
// Command, host-load, status and ALU-side signals of the sequencer.
// master drives commands and ALU results; slave is the sequencer.
interface alu_operand_seq_if;
  import alu_operand_seq_pkg::*;

  logic       START;
  addr_t      RA_SEL;
  addr_t      RB_SEL;
  addr_t      RD_SEL;
  logic [1:0] FUNC_IN;
  logic       LD_EN;
  addr_t      LD_ADDR;
  word_t      LD_DATA;
  logic       LD_ACK;
  logic       BUSY;
  logic       DONE;
  logic       BFLAG;
  word_t      ALU_A;
  word_t      ALU_B;
  logic [1:0] ALU_FUNC;
  logic       ALU_BIN;
  word_t      ALU_OUT;
  logic       ALU_BOUT;

  modport master (
    output START, RA_SEL, RB_SEL, RD_SEL, FUNC_IN,
    output LD_EN, LD_ADDR, LD_DATA,
    output ALU_OUT, ALU_BOUT,
    input  LD_ACK, BUSY, DONE, BFLAG,
    input  ALU_A, ALU_B, ALU_FUNC, ALU_BIN
  );

  modport slave (
    input  START, RA_SEL, RB_SEL, RD_SEL, FUNC_IN,
    input  LD_EN, LD_ADDR, LD_DATA,
    input  ALU_OUT, ALU_BOUT,
    output LD_ACK, BUSY, DONE, BFLAG,
    output ALU_A, ALU_B, ALU_FUNC, ALU_BIN
  );

endinterface

// File: rtl/alu_operand_seq_regfile_1r1w.sv
// NREGS x WIDTH register file, one sync write, one async read.
// Synchronous reset clears every entry.
module regfile_1r1w
  import alu_operand_seq_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  addr_t waddr,
  input  word_t wdata,
  input  addr_t raddr,
  output word_t rdata
);

  word_t mem_q [NREGS];
  word_t mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_operand_seq.sv
// Operand sequencer: fetch A, fetch B, drive ALU, write back.
// Host loads share the single write port only while idle.
module alu_operand_seq
  import alu_operand_seq_pkg::*;
(
  input logic CLK,
  input logic RST,
  alu_operand_seq_if.slave bus
);

  state_e state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  word_t  a_q, a_d;
  word_t  b_q, b_d;
  word_t  res_q, res_d;
  logic   bout_q, bout_d;
  logic   bflag_q, bflag_d;
  logic   bin_q, bin_d;

  addr_t  raddr;
  addr_t  waddr;
  word_t  rdata;
  word_t  wdata;
  logic   we;
  logic   idle;
  logic   ld_ack;
  logic   in_wb;

  assign idle   = (state_q == S_IDLE);
  assign in_wb  = (state_q == S_WB);
  assign ld_ack = bus.LD_EN & idle;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    bout_d  = bout_q;
    bflag_d = bflag_q;
    bin_d   = bin_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          cmd_d.ra   = bus.RA_SEL;
          cmd_d.rb   = bus.RB_SEL;
          cmd_d.rd   = bus.RD_SEL;
          cmd_d.func = bus.FUNC_IN;
          state_d    = S_RDA;
        end
      end
      S_RDA: begin
        a_d     = rdata;
        state_d = S_RDB;
      end
      S_RDB: begin
        b_d     = rdata;
        bin_d   = bflag_q & cmd_q.func[FUNC_CHAIN];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = bus.ALU_OUT;
        bout_d  = bus.ALU_BOUT;
        state_d = S_WB;
      end
      S_WB: begin
        bflag_d = bout_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // WB and host loads never overlap, so the write mux is by state alone
  always_comb begin
    raddr = (state_q == S_RDB) ? cmd_q.rb : cmd_q.ra;
    we    = ld_ack | in_wb;
    waddr = in_wb ? cmd_q.rd : bus.LD_ADDR;
    wdata = in_wb ? res_q : bus.LD_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      bout_q  <= 1'b0;
      bflag_q <= 1'b0;
      bin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      bout_q  <= bout_d;
      bflag_q <= bflag_d;
      bin_q   <= bin_d;
    end
  end

  regfile_1r1w u_rf (
    .clk   (CLK),
    .rst   (RST),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign bus.LD_ACK   = ld_ack;
  assign bus.BUSY     = ~idle;
  assign bus.DONE     = in_wb;
  assign bus.BFLAG    = bflag_q;
  assign bus.ALU_A    = a_q;
  assign bus.ALU_B    = b_q;
  assign bus.ALU_FUNC = cmd_q.func;
  assign bus.ALU_BIN  = bin_q;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Directed bench for alu_operand_seq with a behavioural ALU,
// a register-file model and an operand scoreboard.
module tb_alu_operand_seq;
  import alu_operand_seq_pkg::*;

  typedef struct {
    word_t      a;
    word_t      b;
    logic [1:0] fn;
    logic       bin;
    word_t      res;
    logic       bo;
    addr_t      rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nfail = 0;
  int   done_cnt = 0;
  exp_t sb [$];
  word_t mreg [NREGS];
  logic  mbflag;

  alu_operand_seq_if bus ();

  alu_operand_seq dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] alu_f(
    input word_t a, input word_t b,
    input logic [1:0] fn, input logic bin);
    logic [16:0] r;
    if (fn[0]) r = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    else       r = {1'b0, a} + {1'b0, b} + {16'd0, bin};
    return r;
  endfunction

  always_comb begin
    {bus.ALU_BOUT, bus.ALU_OUT} =
      alu_f(bus.ALU_A, bus.ALU_B, bus.ALU_FUNC, bus.ALU_BIN);
  end

  always @(posedge clk) if (bus.DONE) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input addr_t ad, input word_t dat);
    bus.LD_EN   = 1'b1;
    bus.LD_ADDR = ad;
    bus.LD_DATA = dat;
    #1;
    chk("ld_ack_idle", {31'd0, bus.LD_ACK}, 32'd1);
    mreg[ad] = dat;
    tick();
    bus.LD_EN = 1'b0;
  endtask

  task automatic run_cmd(input addr_t ra, input addr_t rb,
                         input addr_t rd, input logic [1:0] fn,
                         input bit ld_busy, input bit restart);
    exp_t e;
    logic [16:0] r;
    bus.RA_SEL  = ra;
    bus.RB_SEL  = rb;
    bus.RD_SEL  = rd;
    bus.FUNC_IN = fn;
    bus.START   = 1'b1;
    #1;
    if (bus.LD_EN) begin
      chk("ld_ack_with_start", {31'd0, bus.LD_ACK}, 32'd1);
      mreg[bus.LD_ADDR] = bus.LD_DATA;
    end
    e.a   = mreg[ra];
    e.b   = mreg[rb];
    e.fn  = fn;
    e.bin = mbflag & fn[1];
    r     = alu_f(e.a, e.b, e.fn, e.bin);
    e.res = r[15:0];
    e.bo  = r[16];
    e.rd  = rd;
    sb.push_back(e);
    tick();
    // RDA: scramble the selects to prove they were captured
    bus.START   = 1'b0;
    bus.RA_SEL  = ~ra;
    bus.RB_SEL  = ~rb;
    bus.RD_SEL  = ~rd;
    bus.FUNC_IN = ~fn;
    bus.LD_EN   = ld_busy;
    bus.LD_ADDR = 3'd7;
    bus.LD_DATA = 16'hBEEF;
    #1;
    chk("busy_rda", {31'd0, bus.BUSY}, 32'd1);
    if (ld_busy) chk("ld_ack_rda", {31'd0, bus.LD_ACK}, 32'd0);
    tick();
    if (restart) begin
      bus.START   = 1'b1;
      bus.RA_SEL  = 3'd0;
      bus.RB_SEL  = 3'd0;
      bus.RD_SEL  = 3'd7;
      bus.FUNC_IN = 2'b00;
    end
    #1;
    if (ld_busy) chk("ld_ack_rdb", {31'd0, bus.LD_ACK}, 32'd0);
    tick();
    bus.START = 1'b0;
    e = sb.pop_front();
    chk("exec_alu_a", {16'd0, bus.ALU_A}, {16'd0, e.a});
    chk("exec_alu_b", {16'd0, bus.ALU_B}, {16'd0, e.b});
    chk("exec_func", {30'd0, bus.ALU_FUNC}, {30'd0, e.fn});
    chk("exec_bin", {31'd0, bus.ALU_BIN}, {31'd0, e.bin});
    chk("exec_done", {31'd0, bus.DONE}, 32'd0);
    if (ld_busy) chk("ld_ack_exec", {31'd0, bus.LD_ACK}, 32'd0);
    tick();
    chk("wb_done", {31'd0, bus.DONE}, 32'd1);
    chk("wb_alu_a_stable", {16'd0, bus.ALU_A}, {16'd0, e.a});
    if (ld_busy) chk("ld_ack_wb", {31'd0, bus.LD_ACK}, 32'd0);
    mreg[e.rd] = e.res;
    mbflag     = e.bo;
    tick();
    chk("idle_done", {31'd0, bus.DONE}, 32'd0);
    chk("idle_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("idle_bflag", {31'd0, bus.BFLAG}, {31'd0, mbflag});
    if (ld_busy) begin
      chk("ld_ack_first_idle", {31'd0, bus.LD_ACK}, 32'd1);
      mreg[7] = 16'hBEEF;
      tick();
      bus.LD_EN = 1'b0;
    end
  endtask

  initial begin
    int d0;
    for (int i = 0; i < NREGS; i++) mreg[i] = '0;
    mbflag      = 1'b0;
    bus.START   = 1'b0;
    bus.RA_SEL  = '0;
    bus.RB_SEL  = '0;
    bus.RD_SEL  = '0;
    bus.FUNC_IN = '0;
    bus.LD_EN   = 1'b0;
    bus.LD_ADDR = '0;
    bus.LD_DATA = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("rst_done", {31'd0, bus.DONE}, 32'd0);
    chk("rst_bflag", {31'd0, bus.BFLAG}, 32'd0);
    chk("rst_ld_ack", {31'd0, bus.LD_ACK}, 32'd0);
    chk("rst_alu_a", {16'd0, bus.ALU_A}, 32'd0);

    // plain add, no carry
    do_load(3'd1, 16'h0005);
    do_load(3'd2, 16'h0003);
    run_cmd(3'd2, 3'd1, 3'd3, 2'b00, 1'b0, 1'b0);
    // subtract that borrows, sets BFLAG
    run_cmd(3'd2, 3'd1, 3'd4, 2'b01, 1'b0, 1'b0);
    // chained subtract of zeros wraps to 0xFFFF
    do_load(3'd1, 16'h0000);
    do_load(3'd2, 16'h0000);
    run_cmd(3'd1, 3'd2, 3'd5, 2'b11, 1'b0, 1'b0);
    // host load held during a whole command
    run_cmd(3'd3, 3'd5, 3'd6, 2'b00, 1'b1, 1'b0);
    run_cmd(3'd7, 3'd4, 3'd0, 2'b00, 1'b0, 1'b0);
    // load and start in the same cycle
    bus.LD_EN   = 1'b1;
    bus.LD_ADDR = 3'd1;
    bus.LD_DATA = 16'h1234;
    run_cmd(3'd1, 3'd6, 3'd2, 2'b00, 1'b0, 1'b0);
    // START during RDB must be ignored
    d0 = done_cnt;
    run_cmd(3'd2, 3'd1, 3'd4, 2'b01, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    chk("restart_one_done", done_cnt - d0, 32'd1);
    chk("restart_idle", {31'd0, bus.BUSY}, 32'd0);

    // reset in EXEC aborts the command
    bus.RA_SEL  = 3'd3;
    bus.RB_SEL  = 3'd4;
    bus.RD_SEL  = 3'd5;
    bus.FUNC_IN = 2'b01;
    bus.START   = 1'b1;
    tick();
    bus.START = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", {31'd0, bus.BUSY}, 32'd1);
    rst = 1'b1;
    d0  = done_cnt;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("midrst_done", {31'd0, bus.DONE}, 32'd0);
    chk("midrst_bflag", {31'd0, bus.BFLAG}, 32'd0);
    chk("midrst_alu_a", {16'd0, bus.ALU_A}, 32'd0);
    chk("midrst_alu_b", {16'd0, bus.ALU_B}, 32'd0);
    chk("midrst_func", {30'd0, bus.ALU_FUNC}, 32'd0);
    chk("midrst_bin", {31'd0, bus.ALU_BIN}, 32'd0);
    tick();
    chk("midrst_no_wb", done_cnt - d0, 32'd0);
    for (int i = 0; i < NREGS; i++) mreg[i] = '0;
    mbflag = 1'b0;
    run_cmd(3'd4, 3'd5, 3'd6, 2'b11, 1'b0, 1'b0);
    run_cmd(3'd3, 3'd7, 3'd1, 2'b00, 1'b0, 1'b0);
    run_cmd(3'd1, 3'd2, 3'd0, 2'b01, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/alu_operand_seq.md
# alu_operand_seq

Sequencer and register file that sits directly upstream of the 16-bit add/subtract-with-borrow ALU in the NARC datapath. It holds an 8 × 16 register file with one read and one write per clock. On each command it fetches operand A, then operand B, drives them with the function code and borrow-in to the combinational ALU, captures the ALU result and borrow-out, and writes the result back. A host load port fills registers while the sequencer is idle.

## Interface
- `WIDTH`, 16, datapath width; equals the ALU width.
- `NREGS`, 8, register count; address width `AW` = log2(`NREGS`) = 3.

- `CLK`  in  1  sole clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `START`  in  1  command strobe; sampled only in IDLE.
- `RA_SEL`  in  AW  source register for ALU A.
- `RB_SEL`  in  AW  source register for ALU B.
- `RD_SEL`  in  AW  destination register.
- `FUNC_IN`  in  2  bit0: 0 = add, 1 = subtract; bit1: 1 = chain the stored borrow flag.
- `LD_EN`  in  1  host write strobe.
- `LD_ADDR`  in  AW  host write address.
- `LD_DATA`  in  WIDTH  host write data.
- `LD_ACK`  out  1  host write accepted this cycle.
- `BUSY`  out  1  a command is in progress.
- `DONE`  out  1  one-cycle pulse on writeback.
- `BFLAG`  out  1  stored borrow flag.
- `ALU_A`, `ALU_B`  out  WIDTH  operands to the ALU.
- `ALU_FUNC`  out  2  function code to the ALU.
- `ALU_BIN`  out  1  borrow-in to the ALU.
- `ALU_OUT`  in  WIDTH  ALU result.
- `ALU_BOUT`  in  1  ALU borrow-out.

## Operation
- FSM states: IDLE → RDA → RDB → EXEC → WB → IDLE. Every transition is unconditional except IDLE→RDA, which requires `START`.
- IDLE + `START`: capture `RA_SEL`, `RB_SEL`, `RD_SEL` and `FUNC_IN` into command registers. Later input changes have no effect on the command.
- RDA: the read port reads reg[ra] into the A latch.
- RDB: the read port reads reg[rb] into the B latch. When ra = rb, the same value is read again.
- EXEC: the latches drive the ALU.
  - `ALU_FUNC` = captured func.
  - `ALU_BIN` = `BFLAG` & func[1].
  - At the end of the cycle, `ALU_OUT` and `ALU_BOUT` are captured into the result latch.
- WB: write the result latch to reg[rd]; `BFLAG` ← captured borrow; `DONE` = 1.
- `ALU_A`, `ALU_B`, `ALU_FUNC` and `ALU_BIN` are registered or latch-driven. They stay stable from EXEC until the next RDA/RDB reloads them.
- Host load port:
  - `LD_ACK` = `LD_EN` & (state = IDLE), combinational.
  - An acknowledged load writes reg[`LD_ADDR`] ← `LD_DATA` at the clock edge.
  - `LD_EN` while busy is dropped with `LD_ACK` = 0; the host must hold and retry.
- `START` and `LD_EN` in the same IDLE cycle: both are accepted. The load commits at that edge, so RDA in the next cycle reads the new value.
- `START` while not IDLE is ignored; there is no queueing.
- Arithmetic is done entirely in the ALU. The result is truncated to `WIDTH`, and wrap-around is reported only through the borrow.

## Timing
- The only write sources are WB and acknowledged loads, and they are mutually exclusive by state. This gives one write per clock.
- Latency from `START` edge to `DONE` is 4 cycles:
  - `START` sampled at edge 0;
  - RDA in cycle 1, RDB in cycle 2, EXEC in cycle 3;
  - WB/`DONE` in cycle 4;
  - register value and `BFLAG` visible from cycle 5.
- Throughput is one command per 5 cycles. `START` may be asserted in the cycle after `DONE`.
- `BUSY` = 1 in RDA, RDB, EXEC and WB.
- `RST` is synchronous and applies at any point, including mid-command. After the edge:
  - state = IDLE;
  - all registers = 0 and `BFLAG` = 0;
  - latches and `ALU_*` outputs = 0;
  - `BUSY` = `DONE` = `LD_ACK` = 0.
  - A command interrupted by reset performs no writeback.

## Structure
- Shared package holds:
  - `WIDTH`, `AW` and `NREGS`;
  - FSM state encoding (IDLE, RDA, RDB, EXEC, WB; one-hot is preferred for the CPLD);
  - func bit positions (`FUNC_SUB` = 0, `FUNC_CHAIN` = 1).
- One sub-module, `regfile_1r1w`: `NREGS` × `WIDTH` storage with one synchronous-write port and one read port, reset to zero. The top level contains the FSM, command capture, latches and the load arbitration.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Load r1 = 0x0005 and r2 = 0x0003, then command add r3 = r2 + r1 with func 00 → `DONE` 4 cycles after `START`, r3 = 0x0008, `BFLAG` = ALU borrow (bench ALU model).
- Set `BFLAG` to 1 via a prior command that borrows. Command func 11 with r1 = 0x0000 and r2 = 0x0000 → `ALU_BIN` = 1 during EXEC; result and borrow match the ALU model; wrap to 0xFFFF is accepted.
- `LD_EN` asserted every cycle during a command → `LD_ACK` = 0 in all four busy cycles, no register changes except rd, and the load is accepted on the first IDLE cycle.
- `START` and `LD_EN` to r1 = 0x1234 in the same cycle, with ra = r1 → `ALU_A` = 0x1234 in EXEC.
- `START` pulsed again during RDB → ignored: exactly one `DONE` pulse, and the command fields from the first `START` are used.
- `RST` asserted in EXEC → next cycle: state IDLE, rd not written, all registers 0, `BFLAG` 0, `BUSY` 0; a new command then completes normally.
